// File: rtl/asic_ioctrl.sv
// Pad control block: settles safe after reset, then applies per-pad oen/ie/cfg writes; safe pads update in 1 edge, driving pads via a TURN-cycle output-disable turnaround.
// Backpressure: req_ready is low during INIT, TURN and whenever hiz is asserted.
module asic_ioctrl #(
  parameter int NPADS  = 8,
  parameter int PW     = $clog2(NPADS),
  parameter int SETTLE = 16,
  parameter int TURN   = 2
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 hiz,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [PW-1:0]        req_pad,
  input  logic                 req_oen,
  input  logic                 req_ie,
  input  logic [7:0]           req_cfg,
  output logic [NPADS-1:0]     oen,
  output logic [NPADS-1:0]     ie,
  output logic [8*NPADS-1:0]   cfg,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_TURN} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] TURN_LAST   = 8'(TURN - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NPADS-1:0]   oen_q, oen_d;
  logic [NPADS-1:0]   ie_q, ie_d;
  logic [8*NPADS-1:0] cfg_q, cfg_d;
  logic               err_q, err_d;
  logic [PW-1:0]      lat_pad_q, lat_pad_d;
  logic               lat_oen_q, lat_oen_d;
  logic               lat_ie_q, lat_ie_d;
  logic [7:0]         lat_cfg_q, lat_cfg_d;

  logic [NPADS-1:0]   req_sel;
  logic [NPADS-1:0]   lat_sel;
  logic               in_range;
  logic               cur_drv;
  logic               accept;

  assign req_ready = (state_q == ST_IDLE) && !hiz;
  assign accept    = req_valid && req_ready;
  assign done      = (state_q != ST_INIT);
  assign err       = err_q;
  assign oen       = oen_q;
  assign ie        = ie_q;
  assign cfg       = cfg_q;

  // One-hot pad decode; an index with no matching bit is out of range.
  always_comb begin
    req_sel = '0;
    lat_sel = '0;
    for (int k = 0; k < NPADS; k++) begin
      req_sel[k] = (req_pad == PW'(k));
      lat_sel[k] = (lat_pad_q == PW'(k));
    end
    in_range = |req_sel;
    cur_drv  = |(req_sel & ~oen_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    oen_d     = oen_q;
    ie_d      = ie_q;
    cfg_d     = cfg_q;
    err_d     = 1'b0;
    lat_pad_d = lat_pad_q;
    lat_oen_d = lat_oen_q;
    lat_ie_d  = lat_ie_q;
    lat_cfg_d = lat_cfg_q;

    case (state_q)
      ST_INIT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_IDLE: begin
        if (accept) begin
          if (!in_range) begin
            err_d = 1'b1;
          end else if (cur_drv) begin
            // Release the pad first; ie/cfg only change once it has stopped driving.
            oen_d     = oen_q | req_sel;
            lat_pad_d = req_pad;
            lat_oen_d = req_oen;
            lat_ie_d  = req_ie;
            lat_cfg_d = req_cfg;
            cnt_d     = '0;
            state_d   = ST_TURN;
          end else begin
            for (int k = 0; k < NPADS; k++) begin
              if (req_sel[k]) begin
                oen_d[k]          = req_oen;
                ie_d[k]           = req_ie;
                cfg_d[8*k +: 8]   = req_cfg;
              end
            end
          end
        end
      end

      ST_TURN: begin
        if (hiz) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TURN_LAST) begin
          for (int k = 0; k < NPADS; k++) begin
            if (lat_sel[k]) begin
              oen_d[k]        = lat_oen_q;
              ie_d[k]         = lat_ie_q;
              cfg_d[8*k +: 8] = lat_cfg_q;
            end
          end
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    if (hiz) begin
      oen_d = '1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      oen_q     <= '1;
      ie_q      <= '0;
      cfg_q     <= '0;
      err_q     <= 1'b0;
      lat_pad_q <= '0;
      lat_oen_q <= 1'b1;
      lat_ie_q  <= 1'b0;
      lat_cfg_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      oen_q     <= oen_d;
      ie_q      <= ie_d;
      cfg_q     <= cfg_d;
      err_q     <= err_d;
      lat_pad_q <= lat_pad_d;
      lat_oen_q <= lat_oen_d;
      lat_ie_q  <= lat_ie_d;
      lat_cfg_q <= lat_cfg_d;
    end
  end

endmodule

// File: tb/tb_asic_ioctrl.sv
// Bench for asic_ioctrl: directed scenarios plus random traffic against a cycle-level pad model.
module tb_asic_ioctrl;

  localparam int NPADS  = 8;
  localparam int PW     = 4;
  localparam int SETTLE = 16;
  localparam int TURN   = 2;

  logic                clk = 1'b0;
  logic                nreset = 1'b0;
  logic                hiz = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [PW-1:0]       req_pad = '0;
  logic                req_oen = 1'b1;
  logic                req_ie = 1'b0;
  logic [7:0]          req_cfg = '0;
  logic [NPADS-1:0]    oen;
  logic [NPADS-1:0]    ie;
  logic [8*NPADS-1:0]  cfg;
  logic                done;
  logic                err;

  int n_checks = 0;
  int n_errors = 0;

  asic_ioctrl #(.NPADS(NPADS), .PW(PW), .SETTLE(SETTLE), .TURN(TURN)) dut (
    .clk(clk), .nreset(nreset), .hiz(hiz),
    .req_valid(req_valid), .req_ready(req_ready), .req_pad(req_pad),
    .req_oen(req_oen), .req_ie(req_ie), .req_cfg(req_cfg),
    .oen(oen), .ie(ie), .cfg(cfg), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Pad model: per-pad arrays, cycles left in settle / turnaround, pending write.
  logic [NPADS-1:0] m_oen;
  logic [NPADS-1:0] m_ie;
  logic [7:0]       m_cfg [NPADS];
  logic             m_err;
  int               m_init_left;
  int               m_turn_left;
  int               p_pad;
  logic             p_oen, p_ie;
  logic [7:0]       p_cfg;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_oen       = '1;
    m_ie        = '0;
    for (int k = 0; k < NPADS; k++) m_cfg[k] = 8'h00;
    m_err       = 1'b0;
    m_init_left = SETTLE;
    m_turn_left = 0;
  endtask

  function automatic logic m_ready();
    return (m_init_left == 0) && (m_turn_left == 0) && !hiz;
  endfunction

  function automatic logic [63:0] m_cfg_vec();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NPADS; k++) v[8*k +: 8] = m_cfg[k];
    return v;
  endfunction

  task automatic model_edge();
    logic rdy;
    int   p;
    rdy   = m_ready();
    m_err = 1'b0;
    if (!nreset) begin
      model_reset();
    end else begin
      if (m_init_left > 0) begin
        m_init_left--;
      end else if (m_turn_left > 0) begin
        if (hiz) begin
          m_turn_left = 0;
        end else begin
          m_turn_left--;
          if (m_turn_left == 0) begin
            m_oen[p_pad] = p_oen;
            m_ie[p_pad]  = p_ie;
            m_cfg[p_pad] = p_cfg;
          end
        end
      end else if (req_valid && rdy) begin
        p = int'(req_pad);
        if (p >= NPADS) begin
          m_err = 1'b1;
        end else if (!m_oen[p]) begin
          m_oen[p]    = 1'b1;
          p_pad       = p;
          p_oen       = req_oen;
          p_ie        = req_ie;
          p_cfg       = req_cfg;
          m_turn_left = TURN;
        end else begin
          m_oen[p] = req_oen;
          m_ie[p]  = req_ie;
          m_cfg[p] = req_cfg;
        end
      end
      if (hiz) m_oen = '1;
    end
  endtask

  task automatic check_all();
    chk_val("oen",  64'(oen),       64'(m_oen));
    chk_val("ie",   64'(ie),        64'(m_ie));
    chk_val("cfg",  cfg,            m_cfg_vec());
    chk_val("rdy",  64'(req_ready), 64'(m_ready()));
    chk_val("done", 64'(done),      64'(m_init_left == 0));
    chk_val("err",  64'(err),       64'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_req(input logic v, input int pad, input logic o, input logic i, input logic [7:0] c);
    req_valid = v;
    req_pad   = PW'(pad);
    req_oen   = o;
    req_ie    = i;
    req_cfg   = c;
  endtask

  logic [63:0] snap_cfg;
  logic [7:0]  snap_oen;

  initial begin
    model_reset();
    p_pad = 0; p_oen = 1'b1; p_ie = 1'b0; p_cfg = 8'h00;
    cycle();
    cycle();
    chk_val("rst_oen",  64'(oen), 64'hFF);
    chk_val("rst_done", 64'(done), 64'h0);

    // Settle with a request held valid: nothing may be accepted for SETTLE cycles.
    nreset = 1'b1;
    set_req(1'b1, 0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < SETTLE; i++) begin
      chk_val("init_rdy", 64'(req_ready), 64'h0);
      cycle();
    end
    chk_val("init_done", 64'(done), 64'h1);
    chk_val("init_rdy1", 64'(req_ready), 64'h1);

    // Safe pad: direct write, then back-to-back write to pad 4.
    set_req(1'b1, 3, 1'b0, 1'b1, 8'h5A);
    cycle();
    chk_val("p3_oen", 64'(oen[3]), 64'h0);
    chk_val("p3_ie",  64'(ie[3]),  64'h1);
    chk_val("p3_cfg", 64'(cfg[31:24]), 64'h5A);
    chk_val("b2b_rdy", 64'(req_ready), 64'h1);
    set_req(1'b1, 4, 1'b0, 1'b1, 8'h33);
    cycle();
    chk_val("p4_oen", 64'(oen[4]), 64'h0);
    chk_val("p4_cfg", 64'(cfg[39:32]), 64'h33);

    // Driving pad: turnaround path.
    set_req(1'b1, 3, 1'b1, 1'b1, 8'h0F);
    cycle();
    set_req(1'b0, 0, 1'b1, 1'b0, 8'h00);
    chk_val("t1_oen", 64'(oen[3]), 64'h1);
    chk_val("t1_cfg", 64'(cfg[31:24]), 64'h5A);
    chk_val("t1_rdy", 64'(req_ready), 64'h0);
    cycle();
    chk_val("t2_oen", 64'(oen[3]), 64'h1);
    chk_val("t2_cfg", 64'(cfg[31:24]), 64'h5A);
    chk_val("t2_rdy", 64'(req_ready), 64'h0);
    cycle();
    chk_val("t3_cfg", 64'(cfg[31:24]), 64'h0F);
    chk_val("t3_oen", 64'(oen[3]), 64'h1);
    chk_val("t3_rdy", 64'(req_ready), 64'h1);

    // Out-of-range pad index.
    snap_cfg = cfg;
    snap_oen = oen;
    set_req(1'b1, 9, 1'b0, 1'b1, 8'hEE);
    cycle();
    set_req(1'b0, 0, 1'b1, 1'b0, 8'h00);
    chk_val("oor_err", 64'(err), 64'h1);
    chk_val("oor_rdy", 64'(req_ready), 64'h1);
    chk_val("oor_cfg", cfg, snap_cfg);
    chk_val("oor_oen", 64'(oen), 64'(snap_oen));
    cycle();
    chk_val("oor_err0", 64'(err), 64'h0);

    // hiz during turnaround while pads 0 and 3 drive.
    set_req(1'b1, 0, 1'b0, 1'b1, 8'h11);
    cycle();
    set_req(1'b1, 3, 1'b0, 1'b1, 8'h0F);
    cycle();
    set_req(1'b1, 3, 1'b0, 1'b1, 8'hC3);
    cycle();
    set_req(1'b0, 0, 1'b1, 1'b0, 8'h00);
    hiz = 1'b1;
    cycle();
    chk_val("hiz_oen", 64'(oen), 64'hFF);
    for (int i = 0; i < 2; i++) begin
      chk_val("hiz_rdy", 64'(req_ready), 64'h0);
      cycle();
    end
    hiz = 1'b0;
    #1;
    chk_val("hiz_rdy1", 64'(req_ready), 64'h1);
    for (int i = 0; i < 3; i++) cycle();
    chk_val("hiz_cfg3", 64'(cfg[31:24]), 64'h0F);

    // Reset in the middle of a turnaround.
    set_req(1'b1, 1, 1'b0, 1'b1, 8'h21);
    cycle();
    set_req(1'b1, 1, 1'b0, 1'b0, 8'h77);
    cycle();
    set_req(1'b0, 0, 1'b1, 1'b0, 8'h00);
    nreset = 1'b0;
    #1;
    chk_val("mrst_oen",  64'(oen), 64'hFF);
    chk_val("mrst_ie",   64'(ie), 64'h0);
    chk_val("mrst_cfg",  cfg, 64'h0);
    chk_val("mrst_rdy",  64'(req_ready), 64'h0);
    chk_val("mrst_done", 64'(done), 64'h0);
    chk_val("mrst_err",  64'(err), 64'h0);
    model_reset();
    cycle();
    cycle();
    nreset = 1'b1;
    for (int i = 0; i < SETTLE; i++) begin
      hiz = (i >= 4 && i <= 6);
      #1;
      chk_val("rinit_rdy", 64'(req_ready), 64'h0);
      cycle();
    end
    hiz = 1'b0;
    #1;
    chk_val("rinit_rdy1", 64'(req_ready), 64'h1);
    chk_val("rinit_cfg1", 64'(cfg[15:8]), 64'h0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      hiz = ($urandom_range(0, 15) == 0);
      set_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 249) == 0) begin
        nreset = 1'b0;
        #1;
        model_reset();
        check_all();
        cycle();
        nreset = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/asic_ioctrl.md
ASIC_IOCTRL -- requirements
Module: asic_ioctrl

Interface
REQ-001 Parameter NPADS, default 8: number of controlled pads, 2..64.
REQ-002 Parameter PW, default $clog2(NPADS): width of the pad index.
REQ-003 Parameter SETTLE, default 16: post-reset settle cycles, 1..255.
REQ-004 Parameter TURN, default 2: output-disable turnaround cycles, 1..15.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 nreset  input  1  asynchronous, active-low reset.
REQ-007 hiz  input  1  level; forces all pads to the safe state.
REQ-008 req_valid  input  1  configuration request valid.
REQ-009 req_ready  output  1  request accepted when req_valid and req_ready are both 1.
REQ-010 req_pad  input  PW  target pad index.
REQ-011 req_oen, req_ie, req_cfg  input  1, 1, 8  requested oen, ie and cfg for the target pad.
REQ-012 oen  output  NPADS  per-pad output enable (0 = drive), registered.
REQ-013 ie  output  NPADS  per-pad input enable (1 = enable), registered.
REQ-014 cfg  output  8*NPADS  per-pad config; pad k uses bits [8k+7:8k], registered.
REQ-015 done  output  1  initialization complete.
REQ-016 err  output  1  one-cycle pulse when an out-of-range request is accepted.

Function
REQ-017 The FSM SHALL have states INIT, IDLE and TURN.
REQ-018 INIT SHALL hold all pads safe (oen=1, ie=0, cfg=0) and req_ready=0 for SETTLE cycles, then move to IDLE; done SHALL be 1 from the first IDLE cycle onward.
REQ-019 In IDLE, req_ready SHALL be 1 when hiz=0 and 0 when hiz=1.
REQ-020 Accepting a request for a non-driving pad (current oen[pad]=1) SHALL load oen, ie and cfg for that pad on the accepting edge; the FSM SHALL stay in IDLE, sustaining one request per cycle.
REQ-021 Accepting a request for a driving pad (current oen[pad]=0) SHALL set only oen[pad]=1 on the accepting edge, latch the request, and enter TURN with req_ready=0.
REQ-022 TURN SHALL last exactly TURN cycles; on its final edge the latched ie, cfg and oen SHALL be written and the FSM SHALL return to IDLE.
REQ-023 For a driving pad, new values SHALL be visible TURN+1 cycles after the accepting edge, and oen[pad] SHALL read 1 throughout that interval.
REQ-024 A driving pad's cfg or ie SHALL never change on the same edge as, or while, its oen is 0.
REQ-025 A request with req_pad >= NPADS SHALL be accepted with no state change, SHALL pulse err for one cycle, and the FSM SHALL stay in IDLE.
REQ-026 hiz=1 SHALL set every oen bit to 1 on the next edge, leaving ie and cfg unchanged.
REQ-027 hiz=1 during TURN SHALL abort the latched request (nothing written) and return the FSM to IDLE.
REQ-028 hiz=1 during INIT SHALL have no extra effect.
REQ-029 Only one request SHALL be outstanding at a time; req_valid without req_ready SHALL have no effect.
REQ-030 Requests leaving oen[pad]=0 (pad stays driving) SHALL also take the TURN path.

Reset
REQ-031 With nreset=0, outputs SHALL immediately be: oen all 1, ie all 0, cfg all 0, req_ready=0, done=0, err=0, and the FSM in INIT with the settle counter cleared.
REQ-032 Reset asserted mid-TURN SHALL discard the latched request; after release, INIT SHALL rerun its full SETTLE count.
REQ-033 Reset release SHALL be assumed synchronized externally; the block SHALL add no synchronizer.

Verification
REQ-034 Release reset, SETTLE=16, hold req_valid=1 -> req_ready=0 and done=0 for 16 cycles, then done=1 and req_ready=1; no output changes before then.
REQ-035 Pad 3 idle, write oen=0, ie=1, cfg=0x5A -> oen[3]=0, ie[3]=1, cfg[3]=0x5A the next cycle; a back-to-back write to pad 4 is accepted on the following cycle.
REQ-036 Pad 3 driving, TURN=2, write oen=1, ie=1, cfg=0x0F -> oen[3]=1 at +1; cfg[3] stays 0x5A through +2; new values visible at +3; req_ready=0 for 2 cycles.
REQ-037 Write to pad index 9 with NPADS=8 -> err=1 for one cycle, no output change, req_ready stays 1.
REQ-038 Assert hiz in TURN cycle 1 while pads 0 and 3 are driving -> all oen=1 next cycle; the latched cfg is never written; req_ready=0 until hiz drops.
REQ-039 Assert nreset=0 mid-TURN -> outputs are immediately safe; after release, a full 16-cycle INIT precedes req_ready=1.
